// File: rtl/act_pkg.sv
// Shared state type, sigmoid LUT span constants and sizing helpers for act_seq.
// Used by the act_seq sequencer and its combinational SiLU lane unit.
package act_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int X_MIN    = -8;
  localparam int X_MAX    = 8;
  localparam int LUT_SIZE = 1024;
  localparam int IDX_W    = $clog2(LUT_SIZE);

  // Beat counter width for DIM/LANES beats; never narrower than one bit.
  function automatic int beat_w(input int dim, input int lanes);
    return (dim / lanes > 1) ? $clog2(dim / lanes) : 1;
  endfunction

  // Sigmoid at LUT sample i in Q(frac), rounded to nearest.
  // exp is built from a short series on x/16 and squared four times to stay accurate over [-8, 8].
  function automatic int lut_entry(input int i, input int frac);
    real x, t, term, e, s;
    x    = real'(X_MIN) + real'(X_MAX - X_MIN) * real'(i) / real'(LUT_SIZE - 1);
    t    = -x / 16.0;
    term = 1.0;
    e    = 1.0;
    for (int k = 1; k <= 20; k++) begin
      term = term * t / real'(k);
      e    = e + term;
    end
    for (int k = 0; k < 4; k++) e = e * e;
    s = 1.0 / (1.0 + e);
    return int'(s * real'(1 << frac));
  endfunction

endpackage

// File: rtl/act_seq_silu.sv
// Combinational SiLU over DIM elements: y = round(x * sigmoid_lut(clamp(x))), purely combinational.
// No state and no handshake; the caller owns timing and flow control.
module silu
  import act_pkg::*;
#(
  parameter int DIM   = 2,
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic [DIM*WIDTH-1:0] x_vec,
  output logic [DIM*WIDTH-1:0] y_vec
);

  localparam int PW     = 2 * WIDTH + 1;
  localparam int XMIN_Q = X_MIN * (1 << FRAC);
  localparam int XMAX_Q = X_MAX * (1 << FRAC);
  localparam int SPAN_Q = (X_MAX - X_MIN) * (1 << FRAC);
  localparam logic signed [PW-1:0] HALF = PW'(1) << (FRAC - 1);

  logic signed [WIDTH-1:0] lut [LUT_SIZE];

  for (genvar i = 0; i < LUT_SIZE; i++) begin : g_lut
    localparam int ENTRY = lut_entry(i, FRAC);
    assign lut[i] = WIDTH'(ENTRY);
  end

  for (genvar j = 0; j < DIM; j++) begin : g_elem
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] sig;
    logic signed [WIDTH-1:0] y;
    logic signed [31:0]      xc;
    logic [IDX_W-1:0]        idx;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    mag;
    logic signed [PW-1:0]    rnd;

    always_comb begin
      x = x_vec[j*WIDTH +: WIDTH];
      // Clamp only steers the LUT index; the product uses the raw x.
      if (32'(x) < XMIN_Q)      xc = XMIN_Q;
      else if (32'(x) > XMAX_Q) xc = XMAX_Q;
      else                      xc = 32'(x);
      idx  = IDX_W'((xc - XMIN_Q) * (LUT_SIZE - 1) / SPAN_Q);
      sig  = lut[idx];
      prod = PW'(x) * PW'(sig);
      mag  = prod[PW-1] ? -prod : prod;
      rnd  = (mag + HALF) >>> FRAC;
      if (prod[PW-1]) rnd = -rnd;
      y = WIDTH'(rnd);
    end

    assign y_vec[j*WIDTH +: WIDTH] = y;
  end

endmodule

// File: rtl/act_seq.sv
// SiLU sequencer: LANES elements per cycle, result DIM/LANES cycles after accept, held until out_ready.
// Optional ACT_SEQ_BYPASS_EN adds a per-vector bypass input that returns the captured vector unchanged.
module act_seq
  import act_pkg::*;
#(
  parameter int DIM   = 8,
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int LANES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef ACT_SEQ_BYPASS_EN
  input  logic                 bypass,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIM*WIDTH-1:0] in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIM*WIDTH-1:0] out_vec,
  output logic                 busy
);

  localparam int BEATS = DIM / LANES;
  localparam int BW    = beat_w(DIM, LANES);
  localparam int SW    = LANES * WIDTH;

  if (DIM % LANES != 0) begin : g_bad_cfg
    $error("act_seq: DIM must be a multiple of LANES");
  end

  state_t               state;
  logic [BW-1:0]        beat;
  logic [DIM*WIDTH-1:0] in_buf;
  logic [DIM*WIDTH-1:0] out_buf;
  logic [SW-1:0]        lane_x;
  logic [SW-1:0]        lane_y;
  logic [SW-1:0]        lane_res;
  logic                 accept;

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign lane_x   = in_buf[int'(beat)*SW +: SW];
  assign out_vec  = out_buf;

  silu #(
    .DIM   (LANES),
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_silu (
    .x_vec (lane_x),
    .y_vec (lane_y)
  );

`ifdef ACT_SEQ_BYPASS_EN
  logic byp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      byp_q <= 1'b0;
    else if (accept) byp_q <= bypass;
  end

  assign lane_res = byp_q ? lane_x : lane_y;
`else
  assign lane_res = lane_y;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= '0;
      in_buf    <= '0;
      out_buf   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= RUN;
            busy   <= 1'b1;
            beat   <= '0;
            in_buf <= in_vec;
          end
        end
        RUN: begin
          out_buf[int'(beat)*SW +: SW] <= lane_res;
          beat <= beat + 1'b1;
          if (beat == BW'(BEATS - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // Draining and refilling in the same cycle keeps back-to-back vectors gap-free.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (accept) begin
              state  <= RUN;
              beat   <= '0;
              in_buf <= in_vec;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_act_seq.sv
// Scoreboard bench for act_seq: real-valued SiLU reference model, decoupled driver and monitor.
module tb_act_seq;

  localparam int DIM   = 8;
  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam int LANES = 2;
  localparam int BEATS = DIM / LANES;
  localparam int VW    = DIM * WIDTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_vec = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [VW-1:0] out_vec;
  logic          busy;
  logic          byp_drv = 1'b0;

  always #5 clk = ~clk;

  act_seq #(
    .DIM   (DIM),
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .LANES (LANES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef ACT_SEQ_BYPASS_EN
    .bypass    (byp_drv),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .busy      (busy)
  );

  typedef struct {
    logic [VW-1:0] v;
    int            acc;
  } exp_t;

  exp_t          q[$];
  int            n_vec = 0;
  int            n_mis = 0;
  int            cyc = 0;
  int            outstanding = 0;
  int            or_mode = 0;
  logic [VW-1:0] exp_next = '0;
  logic          prev_ov = 1'b0;
  logic          held = 1'b0;
  logic [VW-1:0] held_vec = '0;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: SiLU from the real-valued sigmoid of the quantised LUT sample point.
  function automatic logic [WIDTH-1:0] silu_ref(input logic [WIDTH-1:0] xb);
    int     x, idx, sq;
    real    xr, xs, sig;
    longint p, r;
    x  = int'($signed(xb));
    xr = real'(x) / 256.0;
    if (xr < -8.0) xr = -8.0;
    if (xr > 8.0)  xr = 8.0;
    idx = $rtoi((xr + 8.0) * 1023.0 / 16.0);
    xs  = -8.0 + 16.0 * real'(idx) / 1023.0;
    sig = 1.0 / (1.0 + $exp(-xs));
    sq  = $rtoi(sig * 256.0 + 0.5);
    p   = longint'(x) * longint'(sq);
    r   = (p >= 0) ? (p + 128) / 256 : -((-p + 128) / 256);
    return r[WIDTH-1:0];
  endfunction

  function automatic logic [VW-1:0] model_vec(input logic [VW-1:0] v);
    logic [VW-1:0] e;
    for (int j = 0; j < DIM; j++) e[j*WIDTH +: WIDTH] = silu_ref(v[j*WIDTH +: WIDTH]);
    return e;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    int r;
    for (int j = 0; j < DIM; j++) begin
      if ($urandom_range(0, 3) == 0) r = int'($urandom);
      else r = int'($urandom_range(0, 5200)) - 2600;
      v[j*WIDTH +: WIDTH] = 16'(r);
    end
    return v;
  endfunction

  always @(posedge clk) cyc++;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: everything sampled mid-cycle, reflecting what the next rising edge will see.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", VW'(busy), VW'(outstanding != 0));
      if (out_valid && !prev_ov && q.size() > 0)
        chk("latency", VW'(cyc - (q[0].acc + 1)), VW'(BEATS));
      if (out_valid && !out_ready) begin
        if (held) chk("stall_stable", out_vec, held_vec);
        chk("stall_in_ready", VW'(in_ready), VW'(0));
        held     = 1'b1;
        held_vec = out_vec;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL unexpected_output: got %h expected none", out_vec);
        end else begin
          chk("out_vec", out_vec, q[0].v);
          void'(q.pop_front());
          outstanding--;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{v: exp_next, acc: cyc});
        outstanding++;
      end
      prev_ov = out_valid;
    end
  end

  // Caller is at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [VW-1:0] v, input logic [VW-1:0] e, input logic b, output int waits);
    logic acc;
    acc      = 1'b0;
    waits    = 0;
    in_vec   = v;
    exp_next = e;
    byp_drv  = b;
    in_valid = 1'b1;
    for (int k = 0; k < 500 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    if (!acc) begin
      n_vec++;
      n_mis++;
      $display("FAIL accept_timeout: got no accept expected accept within 500 cycles");
    end
    in_valid = 1'b0;
    in_vec   = rand_vec();
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 300 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      n_vec++;
      n_mis++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int            w;
    logic [VW-1:0] v, e;
    logic [15:0]   d_in  [DIM] = '{16'h0000, 16'hFF00, 16'hF800, 16'h0800,
                                   16'h7FFF, 16'h8000, 16'h0100, 16'hFF00};
    logic [15:0]   d_exp [DIM] = '{16'h0000, 16'hFFBC, 16'h0000, 16'h0800,
                                   16'h0000, 16'h0000, 16'h00BB, 16'hFFBC};

    #3;
    chk("reset_out_valid", VW'(out_valid), VW'(0));
    chk("reset_busy", VW'(busy), VW'(0));
    chk("reset_out_vec", out_vec, VW'(0));
    chk("reset_in_ready", VW'(in_ready), VW'(1));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("first_cycle_in_ready", VW'(in_ready), VW'(1));

    // +1.0 everywhere
    v = {DIM{16'h0100}};
    e = {DIM{16'h00BB}};
    send(v, e, 1'b0, w);

    // Saturation and sign corners; the two out-of-range entries come from the model.
    for (int j = 0; j < DIM; j++) begin
      v[j*WIDTH +: WIDTH] = d_in[j];
      e[j*WIDTH +: WIDTH] = d_exp[j];
    end
    e[4*WIDTH +: WIDTH] = silu_ref(d_in[4]);
    e[5*WIDTH +: WIDTH] = silu_ref(d_in[5]);
    send(v, e, 1'b0, w);
    wait_drain();

    // Hold the result for ten cycles, then drain and refill in the same cycle.
    or_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send({DIM{16'h0100}}, {DIM{16'h00BB}}, 1'b0, w);
    for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
    chk("stall_result_present", VW'(out_valid), VW'(1));
    repeat (10) @(posedge clk);
    @(negedge clk);
    or_mode = 0;
    @(posedge clk);
    #1;
    v = rand_vec();
    send(v, model_vec(v), 1'b0, w);
    chk("b2b_accept_waits", VW'(w), VW'(0));
    wait_drain();

    // Reset while beat 2 is in flight.
    v = rand_vec();
    send(v, model_vec(v), 1'b0, w);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_out_valid", VW'(out_valid), VW'(0));
    chk("midrun_busy", VW'(busy), VW'(0));
    chk("midrun_out_vec", out_vec, VW'(0));
    chk("midrun_in_ready", VW'(in_ready), VW'(1));
    q.delete();
    outstanding = 0;
    held        = 1'b0;
    prev_ov     = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_reset_in_ready", VW'(in_ready), VW'(1));
    repeat (12) @(posedge clk);
    #1;
    chk("no_stale_result", VW'(out_valid), VW'(0));

`ifdef ACT_SEQ_BYPASS_EN
    send({DIM{16'h0100}}, {DIM{16'h0100}}, 1'b1, w);
    send({DIM{16'h0100}}, {DIM{16'h00BB}}, 1'b0, w);
    wait_drain();
`endif

    // Random traffic with random gaps and random consumer backpressure.
    or_mode = 1;
    for (int n = 0; n < 150; n++) begin
      logic b;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      v = rand_vec();
`ifdef ACT_SEQ_BYPASS_EN
      b = 1'($urandom_range(0, 1));
`else
      b = 1'b0;
`endif
      send(v, b ? v : model_vec(v), b, w);
    end
    or_mode = 0;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
